// File: rtl/dmem_pkg.sv
// Shared definitions for dmem_responder: width codes, FSM states and the
// width-code to byte-count decode.
package dmem_pkg;

    typedef enum logic [2:0] {
        MW_B   = 3'b000,
        MW_H   = 3'b001,
        MW_W   = 3'b010,
        MW_D   = 3'b011,
        MW_BU  = 3'b100,
        MW_HU  = 3'b101,
        MW_WU  = 3'b110,
        MW_BAD = 3'b111
    } memwid_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] memwid_bytes(input logic [2:0] memwid);
        case (memwid[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte lane handling for dmem_responder: load extension and store merge over
// an 8-byte little-endian window starting at the access address.
module dmem_align import dmem_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [2:0]            memwid,
    input  logic [7:0][7:0]       rbytes,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [7:0][7:0]       wbytes
);

    logic [3:0] nbytes;
    logic       sign;

    always_comb begin
        nbytes = memwid_bytes(memwid);
        sign   = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (4'(i + 1) == nbytes)
                sign = rbytes[i][7];
        end
        // memwid[2] marks the unsigned load codes
        rdata  = {DATA_WIDTH{sign & ~memwid[2]}};
        wbytes = rbytes;
        for (int unsigned i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                rdata[i*8 +: 8] = rbytes[i];
                wbytes[i]       = wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency byte-addressed data memory with a valid/ready request and
// response channel. Define DMEM_MISALIGN_CHECK_EN to reject misaligned accesses.
module dmem_responder import dmem_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RAM_SIZE   = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [RAM_SIZE-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [2:0]            req_memwid_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_error_o
);

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic [RAM_SIZE-1:0]   addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2:0]            memwid_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  error_q;
    logic                  req_err;
    logic                  commit;

    logic [7:0]            mem [2**RAM_SIZE];
    logic [7:0][7:0]       rbytes;
    logic [7:0][7:0]       wbytes;
    logic [DATA_WIDTH-1:0] ld_data;

    always_comb begin
        req_err = (req_memwid_i == MW_BAD) || (req_write_i && req_memwid_i[2]);
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((req_addr_i & RAM_SIZE'(memwid_bytes(req_memwid_i) - 4'd1)) != '0)
            req_err = 1'b1;
`endif
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    state_nxt = req_err ? RESP : BUSY;
            end
            BUSY: if (cnt == '0) state_nxt = RESP;
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign commit      = (state == BUSY) && (cnt == '0);
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            memwid_q <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid_i) begin
                    addr_q   <= req_addr_i;
                    wdata_q  <= req_wdata_i;
                    memwid_q <= req_memwid_i;
                    write_q  <= req_write_i;
                    if (req_err) begin
                        error_q <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt <= 4'(LATENCY - 1);
                    end
                end
                BUSY: if (cnt == '0) begin
                    error_q <= 1'b0;
                    rdata_q <= write_q ? '0 : ld_data;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready_i) begin
                    error_q <= 1'b0;
                    rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Window reads wrap modulo the memory size, so misaligned accesses at the
    // top of the address space continue at byte 0.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++)
            rbytes[i] = mem[addr_q + RAM_SIZE'(i)];
    end

    always_ff @(posedge clk) begin
        if (commit && write_q) begin
            for (int unsigned i = 0; i < 8; i++)
                mem[addr_q + RAM_SIZE'(i)] <= wbytes[i];
        end
    end

    dmem_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .memwid (memwid_q),
        .rbytes (rbytes),
        .wdata  (wdata_q),
        .rdata  (ld_data),
        .wbytes (wbytes)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-array reference model and a
// per-cycle output comparison; honours DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [11:0] req_addr_i = '0;
    logic [63:0] req_wdata_i = '0;
    logic [2:0]  req_memwid_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] rsp_rdata_o;
    logic        rsp_error_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_WIDTH(64),
        .RAM_SIZE(12),
        .LATENCY(LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_memwid_i (req_memwid_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_error_o  (rsp_error_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mem_m [4096];
    bit          known_m [4096];
    int          cyc = 0;
    bit          busy_m = 1'b0;
    int          due_m = 0;
    bit          exp_err_m = 1'b0;
    logic [63:0] exp_data_m = '0;
    bit          exp_known_m = 1'b0;
    bit          pend_wr = 1'b0;
    logic [11:0] pend_addr;
    logic [63:0] pend_data;
    int          pend_n;

    function automatic int size_of(input logic [2:0] w);
        return 1 << w[1:0];
    endfunction

    function automatic bit err_of(input bit wr, input logic [11:0] a, input logic [2:0] w);
        bit e;
        e = (w == 3'b111) || (wr && w >= 3'b100);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (int'(a) % size_of(w) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    initial begin : model
        int          n;
        int          idx;
        logic [63:0] val;
        logic [63:0] one;
        bit          kn;
        one = 64'd1;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                busy_m  = 1'b0;
                pend_wr = 1'b0;
            end else begin
                cyc++;
                if (busy_m) begin
                    if (cyc == due_m && pend_wr) begin
                        for (int i = 0; i < pend_n; i++) begin
                            idx = (int'(pend_addr) + i) % 4096;
                            mem_m[idx]   = pend_data[8*i +: 8];
                            known_m[idx] = 1'b1;
                        end
                        pend_wr = 1'b0;
                    end else if (cyc > due_m && rsp_ready_i) begin
                        busy_m = 1'b0;
                    end
                end else if (req_valid_i) begin
                    busy_m      = 1'b1;
                    exp_err_m   = err_of(req_write_i, req_addr_i, req_memwid_i);
                    exp_data_m  = '0;
                    exp_known_m = 1'b1;
                    due_m       = cyc + (exp_err_m ? 0 : LAT);
                    n           = size_of(req_memwid_i);
                    if (!exp_err_m && req_write_i) begin
                        pend_wr   = 1'b1;
                        pend_addr = req_addr_i;
                        pend_data = req_wdata_i;
                        pend_n    = n;
                    end else if (!exp_err_m) begin
                        val = '0;
                        kn  = 1'b1;
                        for (int i = 0; i < n; i++) begin
                            idx = (int'(req_addr_i) + i) % 4096;
                            val = val | (64'(mem_m[idx]) << (8*i));
                            kn  = kn & known_m[idx];
                        end
                        if (req_memwid_i < 3'b100 && val[8*n-1])
                            val = val | ~((one << (8*n)) - 64'd1);
                        exp_data_m  = val;
                        exp_known_m = kn;
                    end
                end
            end
        end
    end

    initial begin : compare
        bit vis;
        forever begin
            @(negedge clk);
            vis = busy_m && (cyc >= due_m);
            check("req_ready", req_ready_o, !busy_m);
            check("rsp_valid", rsp_valid_o, vis);
            if (vis) begin
                check("rsp_error", rsp_error_o, exp_err_m);
                if (exp_known_m)
                    check("rsp_rdata", rsp_rdata_o, exp_data_m);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit wr, input logic [11:0] a, input logic [63:0] d,
                         input logic [2:0] w);
        @(posedge clk); #1;
        req_valid_i  = 1'b1;
        req_write_i  = wr;
        req_addr_i   = a;
        req_wdata_i  = d;
        req_memwid_i = w;
        @(posedge clk); #1;
        req_valid_i  = 1'b0;
    endtask

    task automatic await_rsp(input int lat, input bit err, input logic [63:0] data);
        int n = 0;
        while (!rsp_valid_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, lat);
        check("error", rsp_error_o, err);
        check("rdata", rsp_rdata_o, data);
    endtask

    task automatic release_rsp(input int stall);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        check("idle_ready", req_ready_o, 1);
        check("idle_valid", rsp_valid_o, 0);
    endtask

    task automatic xact(input bit wr, input logic [11:0] a, input logic [63:0] d,
                        input logic [2:0] w, input int lat, input bit err,
                        input logic [63:0] data, input int stall);
        issue(wr, a, d, w);
        await_rsp(lat, err, data);
        release_rsp(stall);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready_o, 1);
        check({tag, "_valid"}, rsp_valid_o, 0);
        check({tag, "_error"}, rsp_error_o, 0);
        check({tag, "_rdata"}, rsp_rdata_o, 0);
    endtask

    initial begin : stim
        logic [63:0] ld10;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        #20 rst_n = 1'b1;

        xact(1, 12'h010, 64'h1122334455667788, MW_D, LAT, 0, 64'h0, 0);
        xact(0, 12'h010, 64'h0, MW_D, LAT, 0, 64'h1122334455667788, 0);
        xact(0, 12'h017, 64'h0, MW_B, LAT, 0, 64'h0000000000000011, 0);
        xact(1, 12'h011, 64'h80, MW_B, LAT, 0, 64'h0, 0);
        xact(0, 12'h011, 64'h0, MW_B, LAT, 0, 64'hFFFFFFFFFFFFFF80, 0);
        xact(0, 12'h011, 64'h0, MW_BU, LAT, 0, 64'h0000000000000080, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        xact(1, 12'h012, 64'hDEADBEEF, MW_W, 0, 1, 64'h0, 0);
        xact(1, 12'hFFF, 64'hA55A, MW_H, 0, 1, 64'h0, 0);
        ld10 = 64'h1122334455668088;
`else
        xact(1, 12'h012, 64'hDEADBEEF, MW_W, LAT, 0, 64'h0, 0);
        xact(0, 12'h012, 64'h0, MW_WU, LAT, 0, 64'h00000000DEADBEEF, 0);
        xact(0, 12'h012, 64'h0, MW_W, LAT, 0, 64'hFFFFFFFFDEADBEEF, 0);
        xact(1, 12'hFFF, 64'hA55A, MW_H, LAT, 0, 64'h0, 0);
        xact(0, 12'h000, 64'h0, MW_BU, LAT, 0, 64'h00000000000000A5, 0);
        xact(0, 12'hFFF, 64'h0, MW_HU, LAT, 0, 64'h000000000000A55A, 0);
        xact(0, 12'hFFF, 64'h0, MW_H, LAT, 0, 64'hFFFFFFFFFFFFA55A, 0);
        ld10 = 64'h1122DEADBEEF8088;
`endif
        xact(0, 12'h010, 64'h0, MW_D, LAT, 0, ld10, 0);

        xact(1, 12'h010, 64'hFF, MW_BU, 0, 1, 64'h0, 0);
        xact(1, 12'h010, 64'hFF, MW_WU, 0, 1, 64'h0, 0);
        xact(1, 12'h010, 64'hFF, MW_BAD, 0, 1, 64'h0, 0);
        xact(0, 12'h010, 64'h0, MW_BAD, 0, 1, 64'h0, 0);
        xact(0, 12'h010, 64'h0, MW_D, LAT, 0, ld10, 5);

        xact(1, 12'h040, 64'h0123456789ABCDEF, MW_D, LAT, 0, 64'h0, 0);
        issue(1, 12'h040, 64'hCAFEF00DCAFEF00D, MW_D);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("busy_rst");
        @(posedge clk); #3 rst_n = 1'b1;
        xact(0, 12'h040, 64'h0, MW_D, LAT, 0, 64'h0123456789ABCDEF, 0);

        issue(0, 12'h040, 64'h0, MW_D);
        await_rsp(LAT, 0, 64'h0123456789ABCDEF);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("resp_rst");
        @(posedge clk); #3 rst_n = 1'b1;
        xact(0, 12'h010, 64'h0, MW_D, LAT, 0, ld10, 0);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d of %0d checks bad", n_bad, n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
